// File: rtl/i2c_ctrl_pkg.sv
// i2c_ctrl_pkg: shared encodings for the I2C transfer sequencer.
//   state_e : sequencer FSM states (IDLE must encode as zero).
//   cond_e  : bus condition request codes driven on cond_req_o.
//   kind_e  : byte-type codes driven on byte_kind_o.
package i2c_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_ADDR  = 3'd2,
    ST_WDATA = 3'd3,
    ST_RDATA = 3'd4,
    ST_END   = 3'd5,
    ST_DONE  = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    COND_NONE   = 2'b00,
    COND_START  = 2'b01,
    COND_STOP   = 2'b10,
    COND_RSTART = 2'b11
  } cond_e;

  typedef enum logic [1:0] {
    KIND_ADDR    = 2'b00,
    KIND_WDATA   = 2'b01,
    KIND_RD_ACK  = 2'b10,
    KIND_RD_NACK = 2'b11
  } kind_e;

endpackage

// File: rtl/i2c_xfer_seq.sv
// i2c_xfer_seq: sequences one I2C transaction (start, address byte, N data
// bytes, stop or repeated start) around an external byte shifter and bus
// condition generator. No data passes through; only handshakes and FIFO
// strobes.
//   in : i2c_core_clk_i, rst_ni, start_i, rw_i, repeat_start_i, nbytes_i,
//        abort_i, tx_empty_i, rx_full_i, byte_done_i, ack_i, bus_done_i
//   out: cond_req_o, byte_req_o, byte_kind_o, r_tx_fifo_en_o,
//        w_rx_fifo_en_o, busy_o, done_o, nack_o (all registered)
module i2c_xfer_seq
  import i2c_ctrl_pkg::*;
#(
  parameter int DATASIZE = 8,
  parameter int CNTSIZE  = 8
) (
  input  logic               i2c_core_clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic               rw_i,
  input  logic               repeat_start_i,
  input  logic [CNTSIZE-1:0] nbytes_i,
  input  logic               abort_i,
  input  logic               tx_empty_i,
  input  logic               rx_full_i,
  input  logic               byte_done_i,
  input  logic               ack_i,
  input  logic               bus_done_i,
  output logic [1:0]         cond_req_o,
  output logic               byte_req_o,
  output logic [1:0]         byte_kind_o,
  output logic               r_tx_fifo_en_o,
  output logic               w_rx_fifo_en_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               nack_o
);

  if (DATASIZE < 1) begin : g_bad_datasize
    $error("DATASIZE must be at least 1");
  end

  localparam logic [CNTSIZE-1:0] CntOne = CNTSIZE'(1);

  state_e             r_state, w_nxt_state;
  cond_e              r_cond, w_nxt_cond;
  kind_e              r_kind, w_nxt_kind;
  logic [CNTSIZE-1:0] r_cnt, w_nxt_cnt;
  logic               r_rw, w_nxt_rw;
  logic               r_rpt, w_nxt_rpt;
  logic               r_nack, w_nxt_nack;
  logic               r_abort, w_nxt_abort;
  logic               r_byte_req, w_nxt_req;
  logic               r_tx_pop, w_nxt_pop;
  logic               r_rx_push, w_nxt_push;
  logic               r_busy, r_done;
  logic               w_flow_block, w_strobe, w_last, w_is_rd;

  assign w_is_rd      = (r_state == ST_RDATA);
  assign w_flow_block = w_is_rd ? rx_full_i : tx_empty_i;
  // A FIFO strobe issued last cycle has not yet updated the FIFO flags, so
  // the flag seen this cycle is stale; never launch a byte on it.
  assign w_strobe     = r_tx_pop | r_rx_push;
  assign w_last       = (r_cnt == CntOne);

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_kind  = r_kind;
    w_nxt_cnt   = r_cnt;
    w_nxt_rw    = r_rw;
    w_nxt_rpt   = r_rpt;
    w_nxt_nack  = r_nack;
    w_nxt_abort = r_abort;
    w_nxt_req   = r_byte_req;
    w_nxt_pop   = 1'b0;
    w_nxt_push  = 1'b0;
    w_nxt_cond  = COND_NONE;

    unique case (r_state)
      ST_IDLE: begin
        if (start_i) begin
          w_nxt_state = ST_START;
          w_nxt_rw    = rw_i;
          w_nxt_rpt   = repeat_start_i;
          w_nxt_cnt   = nbytes_i;
          w_nxt_nack  = 1'b0;
          w_nxt_abort = 1'b0;
        end
      end
      ST_START: if (bus_done_i) w_nxt_state = ST_ADDR;
      ST_ADDR, ST_WDATA, ST_RDATA: begin
        if (r_byte_req) begin
          // Abort seen mid-byte is remembered; the byte finishes first.
          if (abort_i) w_nxt_abort = 1'b1;
          if (byte_done_i) begin
            w_nxt_req = 1'b0;
            if (w_is_rd) w_nxt_push = 1'b1;
            else         w_nxt_pop  = 1'b1;
            if (r_state != ST_ADDR && r_cnt != '0) w_nxt_cnt = r_cnt - CntOne;
            if (!w_is_rd && ack_i) begin
              w_nxt_nack  = 1'b1;
              w_nxt_state = ST_END;
            end else if (abort_i || r_abort) begin
              w_nxt_state = ST_END;
            end else if (r_state == ST_ADDR) begin
              if (r_cnt == '0) w_nxt_state = ST_END;
              else             w_nxt_state = r_rw ? ST_RDATA : ST_WDATA;
            end else if (w_last) begin
              w_nxt_state = ST_END;
            end
          end
        end else if (abort_i) begin
          w_nxt_abort = 1'b1;
          w_nxt_state = ST_END;
        end else if (!w_strobe && !w_flow_block) begin
          w_nxt_req = 1'b1;
          unique case (r_state)
            ST_ADDR:  w_nxt_kind = KIND_ADDR;
            ST_WDATA: w_nxt_kind = KIND_WDATA;
            default:  w_nxt_kind = w_last ? KIND_RD_NACK : KIND_RD_ACK;
          endcase
        end
      end
      ST_END:  if (bus_done_i) w_nxt_state = ST_DONE;
      ST_DONE: w_nxt_state = ST_IDLE;
      default: w_nxt_state = ST_IDLE;
    endcase

    // Condition output is a function of the state being entered so the
    // registered value lines up with that state.
    unique case (w_nxt_state)
      ST_START: w_nxt_cond = COND_START;
      ST_END:   w_nxt_cond = (w_nxt_rpt && !w_nxt_nack && !w_nxt_abort) ?
                             COND_RSTART : COND_STOP;
      default:  w_nxt_cond = COND_NONE;
    endcase
  end

  always_ff @(posedge i2c_core_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= ST_IDLE;
      r_cond     <= COND_NONE;
      r_kind     <= KIND_ADDR;
      r_cnt      <= '0;
      r_rw       <= 1'b0;
      r_rpt      <= 1'b0;
      r_nack     <= 1'b0;
      r_abort    <= 1'b0;
      r_byte_req <= 1'b0;
      r_tx_pop   <= 1'b0;
      r_rx_push  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_nxt_state;
      r_cond     <= w_nxt_cond;
      r_kind     <= w_nxt_kind;
      r_cnt      <= w_nxt_cnt;
      r_rw       <= w_nxt_rw;
      r_rpt      <= w_nxt_rpt;
      r_nack     <= w_nxt_nack;
      r_abort    <= w_nxt_abort;
      r_byte_req <= w_nxt_req;
      r_tx_pop   <= w_nxt_pop;
      r_rx_push  <= w_nxt_push;
      r_busy     <= (w_nxt_state != ST_IDLE);
      r_done     <= (w_nxt_state == ST_DONE);
    end
  end

  assign cond_req_o     = r_cond;
  assign byte_req_o     = r_byte_req;
  assign byte_kind_o    = r_kind;
  assign r_tx_fifo_en_o = r_tx_pop;
  assign w_rx_fifo_en_o = r_rx_push;
  assign busy_o         = r_busy;
  assign done_o         = r_done;
  assign nack_o         = r_nack;

endmodule
